// File: rtl/multi_8_8_pp_combine_pkg.sv
// -----------------------------------------------------------------------------
// multi_8_8_pp_combine_pkg
//
// Shared constants for the 8x8 abacus multiplier combiner.
//   - PP_W / PROD_W  : partial-product width and full product width
//   - ST_*           : FSM state encoding for the combiner (IDLE, ACC, DONE)
//   - STEP_LAST      : step index of the final shift-add
//   - step_shift()   : left-shift amount applied to the term added at each step
//
// Step 0 corresponds to pp0 (loaded directly, no shift).
// Steps 1..3 add pp1<<4, pp2<<4 and pp3<<8.
// -----------------------------------------------------------------------------
package multi_8_8_pp_combine_pkg;

    localparam int PP_W    = 8;
    localparam int PROD_W  = 16;
    localparam int STEP_W  = 2;
    localparam int SHIFT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [STEP_W-1:0] STEP_LAST = 2'd3;

    // Bit position of each partial product inside the 16-bit product.
    function automatic logic [SHIFT_W-1:0] step_shift(input logic [STEP_W-1:0] step);
        logic [SHIFT_W-1:0] sh;
        case (step)
            2'd0:    sh = 4'd0;
            2'd1:    sh = 4'd4;
            2'd2:    sh = 4'd4;
            default: sh = 4'd8;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/multi_8_8_pp_combine_pp_shift_add.sv
// -----------------------------------------------------------------------------
// multi_8_8_pp_combine_pp_shift_add
//
// Combinational shift-add used once per ACC step by the combiner:
//     sum = acc + (zero_extend(term) << step_shift(step))
//
// Ports:
//   acc   in  PROD_W  running accumulator
//   term  in  PP_W    partial product selected for this step
//   step  in  2       step index, selects the shift amount
//   sum   out PROD_W  acc plus the aligned term (carry-out discarded; the
//                     largest 8x8 product 0xFE01 always fits in 16 bits)
// -----------------------------------------------------------------------------
module multi_8_8_pp_combine_pp_shift_add
    import multi_8_8_pp_combine_pkg::*;
#(
    parameter int PP_W   = multi_8_8_pp_combine_pkg::PP_W,
    parameter int PROD_W = multi_8_8_pp_combine_pkg::PROD_W
) (
    input  logic [PROD_W-1:0] acc,
    input  logic [PP_W-1:0]   term,
    input  logic [1:0]        step,
    output logic [PROD_W-1:0] sum
);

    logic [PROD_W-1:0] term_ext;
    logic [PROD_W-1:0] term_aligned;

    always_comb begin
        term_ext     = {{(PROD_W-PP_W){1'b0}}, term};
        term_aligned = term_ext << step_shift(step);
        sum          = acc + term_aligned;
    end

endmodule

// File: rtl/multi_8_8_pp_combine.sv
// -----------------------------------------------------------------------------
// multi_8_8_pp_combine
//
// Sequential combiner for the 8x8 abacus multiplier. Accepts the four
// registered 4x4 partial products as one aligned set and folds them into a
// 16-bit product with a single shared adder over three cycles:
//     product = pp0 + (pp1<<4) + (pp2<<4) + (pp3<<8)
// The result is then held under a valid/ready handshake.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   clr_n      in   1       asynchronous active-low reset
//   in_valid   in   1       pp0..pp3 valid
//   in_ready   out  1       set can be accepted (IDLE only)
//   pp0..pp3   in   PP_W    partial products (A_lo*B_lo, A_hi*B_lo,
//                           A_lo*B_hi, A_hi*B_hi)
//   product    out  PROD_W  registered product
//   out_valid  out  1       product valid (DONE)
//   out_ready  in   1       consumer accepts product
//   busy       out  1       combining or holding a result (ACC or DONE)
//
// Timing: capture at E0, adds at E1..E3, out_valid high after E3. With
// out_ready high the handshake lands at E4 and the next set can be
// captured at E5. PROD_W must equal 2*PP_W.
// -----------------------------------------------------------------------------
module multi_8_8_pp_combine
    import multi_8_8_pp_combine_pkg::*;
#(
    parameter int PP_W   = multi_8_8_pp_combine_pkg::PP_W,
    parameter int PROD_W = multi_8_8_pp_combine_pkg::PROD_W
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PP_W-1:0]   pp0,
    input  logic [PP_W-1:0]   pp1,
    input  logic [PP_W-1:0]   pp2,
    input  logic [PP_W-1:0]   pp3,
    output logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    logic [1:0]        state;
    logic [1:0]        step;
    logic [PROD_W-1:0] acc;
    logic [PP_W-1:0]   pp1_hold;
    logic [PP_W-1:0]   pp2_hold;
    logic [PP_W-1:0]   pp3_hold;
    logic [PROD_W-1:0] product_r;

    logic [PP_W-1:0]   term;
    logic [PROD_W-1:0] sum;

    // Term select for the shared adder: step 1..3 picks the held pp1..pp3.
    always_comb begin
        term = '0;
        case (step)
            2'd1:    term = pp1_hold;
            2'd2:    term = pp2_hold;
            2'd3:    term = pp3_hold;
            default: term = '0;
        endcase
    end

    multi_8_8_pp_combine_pp_shift_add #(
        .PP_W   (PP_W),
        .PROD_W (PROD_W)
    ) u_shift_add (
        .acc  (acc),
        .term (term),
        .step (step),
        .sum  (sum)
    );

    // Capture / accumulate / hold
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= ST_IDLE;
            step      <= 2'd0;
            acc       <= '0;
            pp1_hold  <= '0;
            pp2_hold  <= '0;
            pp3_hold  <= '0;
            product_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // in_ready is implied by being in IDLE.
                    if (in_valid) begin
                        pp1_hold <= pp1;
                        pp2_hold <= pp2;
                        pp3_hold <= pp3;
                        acc      <= {{(PROD_W-PP_W){1'b0}}, pp0};
                        step     <= 2'd1;
                        state    <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc <= sum;
                    if (step == STEP_LAST) begin
                        // Final sum goes straight to the output register so
                        // out_valid and product appear together after E3.
                        product_r <= sum;
                        step      <= 2'd0;
                        state     <= ST_DONE;
                    end else begin
                        step <= step + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    step  <= 2'd0;
                end
            endcase
        end
    end

    // Handshake outputs decoded from registered state only.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state == ST_ACC) || (state == ST_DONE);
        product   = product_r;
    end

endmodule
